// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Logic, add/sub, compare and shift ops finish in one cycle. Unsigned
// multiply/divide iterate one bit per cycle.
// Build option: define ALU_SEQ_MULDIV_EN to implement opcodes 1100-1111
// (MUL, MULHU, DIVU, REMU). Without it they complete as illegal opcodes and
// the iterative datapath and BUSY state are not built.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             negative,
    output logic             zero,
    output logic             illegal
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MULDIV_EN
        ST_BUSY = 2'd1,
`endif
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated straight from the input buses; its
    // result is captured into the output registers on the accepting edge.
    // ------------------------------------------------------------------
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ill;

    assign shamt = SrcB[SH_W-1:0];

    // Decode and compute the one-cycle ops; anything not listed is illegal.
    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        case (Operation)
            4'b0000: sc_res = SrcA & SrcB;
            4'b0001: sc_res = SrcA | SrcB;
            4'b0011: sc_res = SrcA ^ SrcB;
            4'b0010: sc_res = SrcA + SrcB;
            4'b0110: sc_res = SrcA - SrcB;
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            4'b1000: sc_res = SrcA << shamt;
            4'b1001: sc_res = SrcA >> shamt;
            4'b1010: sc_res = $signed(SrcA) >>> shamt;
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative multiply/divide. One 2*WIDTH accumulator serves both:
    //   multiply: {partial product, remaining multiplier bits}, shifts right
    //   divide:   {partial remainder, dividend/quotient bits}, shifts left
    // opnd holds the multiplicand (mul) or the divisor (div).
    // md_op[1] selects divide, md_op[0] selects the upper half as result;
    // after the last step, hi/lo are MULHU/MUL or REMU/DIVU respectively.
    // ------------------------------------------------------------------
    logic [1:0]         md_op;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   md_res;
    logic               is_md;

    assign is_md = (Operation[3:2] == 2'b11);

    // One shift-add or restoring shift-subtract step per cycle. A zero
    // divisor always "fits", which naturally yields all-ones quotient and
    // the dividend as remainder.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        div_ge   = (div_sh >= {1'b0, opnd});
        if (!md_op[1])
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (div_ge)
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        md_res = md_op[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    end
`endif

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            md_op     <= '0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
                        if (is_md) begin
                            state <= ST_BUSY;
                            md_op <= Operation[1:0];
                            cnt   <= CNT_W'(WIDTH);
                            opnd  <= Operation[1] ? SrcB : SrcA;
                            acc   <= {{WIDTH{1'b0}}, (Operation[1] ? SrcA : SrcB)};
                        end else
`endif
                        begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            ALUResult <= sc_res;
                            negative  <= sc_res[WIDTH-1];
                            zero      <= (sc_res == '0);
                            illegal   <= sc_ill;
                        end
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                ST_BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        ALUResult <= md_res;
                        negative  <= md_res[WIDTH-1];
                        zero      <= (md_res == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        ALUResult <= '0;
                        negative  <= 1'b0;
                        zero      <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); follows ALU_SEQ_MULDIV_EN for
// the expected behaviour of opcodes 1100-1111.
module tb_alu_seq;

    localparam int W = 32;

`ifdef ALU_SEQ_MULDIV_EN
    localparam int   MD_LAT = 33;
    localparam logic MD_ILL = 1'b0;
`else
    localparam int   MD_LAT = 1;
    localparam logic MD_ILL = 1'b1;
`endif

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_XOR = 4'b0011,
                           OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_SLTU = 4'b0111,
                           OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010,
                           OP_MUL = 4'b1100, OP_MULHU = 4'b1101,
                           OP_DIVU = 4'b1110, OP_REMU = 4'b1111, OP_BAD = 4'b0100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [3:0]   Operation = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUResult;
    logic         negative;
    logic         zero;
    logic         illegal;

    int n_chk = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
        .negative(negative), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] mdv(input logic [W-1:0] v);
        return MD_ILL ? '0 : v;
    endfunction

    // Issue one op, time it, check result/flags, optionally hold, then retire.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] exp_res,
                         input logic exp_ill, input int hold);
        int   lat;
        logic rdy_seen;
        logic stable;
        logic [W-1:0] r0;
        @(negedge clk);
        SrcA = a; SrcB = b; Operation = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
        lat = 1;
        rdy_seen = in_ready;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            rdy_seen |= in_ready;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " in_ready low"}, 64'(rdy_seen), 64'(0));
        chk({tag, " result"}, 64'(ALUResult), 64'(exp_res));
        chk({tag, " flags n/z/ill"}, 64'({negative, zero, illegal}),
            64'({exp_res[W-1], (exp_res == '0), exp_ill}));
        if (hold > 0) begin
            stable = 1'b1;
            r0 = ALUResult;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || ALUResult !== r0 ||
                    negative !== exp_res[W-1] || zero !== (exp_res == '0))
                    stable = 1'b0;
            end
            chk({tag, " hold stable"}, 64'(stable), 64'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " retire rdy/vld/res"}, 64'({in_ready, out_valid, ALUResult}),
            64'({1'b1, 1'b0, {W{1'b0}}}));
    endtask

    initial begin
        #12;
        chk("reset state", 64'({in_ready, out_valid, negative, zero, illegal, ALUResult}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle after reset", 64'({in_ready, out_valid, ALUResult}),
            64'({1'b1, 1'b0, {W{1'b0}}}));

        do_op("SUB 5-5",   OP_SUB,  32'd5,          32'd5,  1, 32'h0000_0000, 1'b0, 0);
        do_op("SUB 3-7",   OP_SUB,  32'd3,          32'd7,  1, 32'hFFFF_FFFC, 1'b0, 5);
        do_op("ADD wrap",  OP_ADD,  32'hFFFF_FFFF,  32'd1,  1, 32'h0000_0000, 1'b0, 0);
        do_op("SRA",       OP_SRA,  32'h8000_0000,  32'd4,  1, 32'hF800_0000, 1'b0, 0);
        do_op("SRL",       OP_SRL,  32'h8000_0000,  32'd36, 1, 32'h0800_0000, 1'b0, 0);
        do_op("SLL",       OP_SLL,  32'd1,          32'h3F, 1, 32'h8000_0000, 1'b0, 0);
        do_op("AND",       OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 0);
        do_op("OR",        OP_OR,   32'hF0F0_F0F0,  32'h0F00_0F00, 1, 32'hFFF0_FFF0, 1'b0, 0);
        do_op("XOR",       OP_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0, 0);
        do_op("SLTU lt",   OP_SLTU, 32'd3,          32'hFFFF_FFFF, 1, 32'd1, 1'b0, 0);
        do_op("SLTU ge",   OP_SLTU, 32'hFFFF_FFFF,  32'd3,  1, 32'd0, 1'b0, 0);
        do_op("illegal",   OP_BAD,  32'd1,          32'd2,  1, 32'd0, 1'b1, 0);

        do_op("MUL 2^32",  OP_MUL,   32'h0001_0000, 32'h0001_0000, MD_LAT, mdv(32'h0), MD_ILL, 0);
        do_op("MULHU 2^32",OP_MULHU, 32'h0001_0000, 32'h0001_0000, MD_LAT, mdv(32'h1), MD_ILL, 0);
        do_op("MUL 7*6",   OP_MUL,   32'd7,         32'd6,         MD_LAT, mdv(32'd42), MD_ILL, 0);
        do_op("MULHU max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_LAT, mdv(32'hFFFF_FFFE), MD_ILL, 0);
        do_op("DIVU 100/7",OP_DIVU,  32'd100,       32'd7,         MD_LAT, mdv(32'd14), MD_ILL, 0);
        do_op("REMU 100/7",OP_REMU,  32'd100,       32'd7,         MD_LAT, mdv(32'd2),  MD_ILL, 2);
        do_op("DIVU 9/0",  OP_DIVU,  32'd9,         32'd0,         MD_LAT, mdv(32'hFFFF_FFFF), MD_ILL, 0);
        do_op("REMU 9/0",  OP_REMU,  32'd9,         32'd0,         MD_LAT, mdv(32'd9),  MD_ILL, 0);

        // Reset ten cycles into a divide (or during DONE when muldiv is off).
        @(negedge clk);
        SrcA = 32'd1000; SrcB = 32'd3; Operation = OP_DIVU; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("mid-op in_ready", 64'({in_ready, out_valid}), 64'({1'b0, MD_ILL}));
        #2;
        reset = 1'b1;
        #1;
        chk("async reset outputs", 64'({in_ready, out_valid, negative, zero, illegal, ALUResult}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}}));
        @(negedge clk);
        reset = 1'b0;
        do_op("ADD after reset", OP_ADD, 32'd2, 32'd2, 1, 32'd4, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
